// File: rtl/vending_core.sv
// Clocked vending controller: credit accumulation, per-slot price/stock table,
// single-cycle vend pulse and largest-first change dispensing over a ready/valid handshake.
module vending_core #(
  parameter int unsigned NUM_SLOTS     = 9,
  parameter int unsigned PRICE_W       = 12,
  parameter int unsigned STOCK_W       = 4,
  parameter int unsigned INIT_STOCK    = 4,
  parameter int unsigned DEFAULT_PRICE = 125,
  parameter int unsigned MAX_CREDIT    = 995,
  localparam int unsigned IDX_W        = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           coin_in,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  input  logic                 cancel,
  input  logic                 price_we,
  input  logic [IDX_W-1:0]     price_idx,
  input  logic [PRICE_W-1:0]   price_data,
  input  logic                 restock,
  output logic [PRICE_W-1:0]   credit,
  output logic [PRICE_W-1:0]   disp_value,
  output logic                 disp_is_price,
  output logic [NUM_SLOTS-1:0] green_led,
  output logic [NUM_SLOTS-1:0] red_led,
  output logic                 coin_reject,
  output logic                 vend_valid,
  output logic [IDX_W-1:0]     vend_idx,
  output logic                 chg_valid,
  output logic [5:0]           chg_coin,
  input  logic                 chg_ready,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [PRICE_W-1:0] change, change_nxt, credit_nxt, disp_value_nxt;
  logic               disp_is_price_nxt, coin_reject_nxt, vend_valid_nxt, chg_valid_nxt, busy_nxt;
  logic [IDX_W-1:0]   vend_idx_nxt;
  logic [5:0]         chg_coin_nxt;
  logic               price_wr, restock_wr, stock_dec;

  logic [PRICE_W-1:0] price [NUM_SLOTS];
  logic [STOCK_W-1:0] stock [NUM_SLOTS];

  function automatic logic [PRICE_W-1:0] coin_value(input logic [5:0] c);
    case (c)
      6'b000001: coin_value = PRICE_W'(5);
      6'b000010: coin_value = PRICE_W'(10);
      6'b000100: coin_value = PRICE_W'(25);
      6'b001000: coin_value = PRICE_W'(50);
      6'b010000: coin_value = PRICE_W'(100);
      6'b100000: coin_value = PRICE_W'(500);
      default:   coin_value = '0;
    endcase
  endfunction

  // A residue below 5c (odd price) is paid out as one 5c coin so change always terminates.
  function automatic logic [5:0] pick_coin(input logic [PRICE_W-1:0] v);
    if (v >= PRICE_W'(500))      pick_coin = 6'b100000;
    else if (v >= PRICE_W'(100)) pick_coin = 6'b010000;
    else if (v >= PRICE_W'(50))  pick_coin = 6'b001000;
    else if (v >= PRICE_W'(25))  pick_coin = 6'b000100;
    else if (v >= PRICE_W'(10))  pick_coin = 6'b000010;
    else                         pick_coin = 6'b000001;
  endfunction

  logic               sel_ok, idx_ok, coin_ok, can_vend;
  logic [PRICE_W-1:0] coin_sum, sel_price, paid, remain;

  assign sel_ok    = 32'(sel_idx) < NUM_SLOTS;
  assign idx_ok    = 32'(price_idx) < NUM_SLOTS;
  assign coin_sum  = credit + coin_value(coin_in);
  assign coin_ok   = $onehot(coin_in) && (coin_sum <= PRICE_W'(MAX_CREDIT));
  assign sel_price = sel_ok ? price[sel_idx] : '0;
  assign can_vend  = sel_valid && sel_ok && (credit != '0) && (stock[sel_idx] != '0)
                     && (credit >= sel_price);
  assign paid      = coin_value(chg_coin);
  assign remain    = (change > paid) ? change - paid : '0;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt         = state;
    credit_nxt        = credit;
    change_nxt        = change;
    disp_value_nxt    = disp_value;
    disp_is_price_nxt = disp_is_price;
    coin_reject_nxt   = 1'b0;
    vend_valid_nxt    = 1'b0;
    vend_idx_nxt      = vend_idx;
    chg_valid_nxt     = chg_valid;
    chg_coin_nxt      = chg_coin;
    price_wr          = 1'b0;
    restock_wr        = 1'b0;
    stock_dec         = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        price_wr   = (state == S_IDLE) && price_we && idx_ok;
        restock_wr = (state == S_IDLE) && restock && idx_ok;
        if (cancel && credit != '0) begin
          change_nxt        = credit;
          credit_nxt        = '0;
          state_nxt         = S_CHANGE;
          chg_valid_nxt     = 1'b1;
          chg_coin_nxt      = pick_coin(credit);
          disp_value_nxt    = credit;
          disp_is_price_nxt = 1'b0;
          coin_reject_nxt   = |coin_in;
        end else if (can_vend) begin
          change_nxt      = credit - sel_price;
          credit_nxt      = '0;
          state_nxt       = S_VEND;
          vend_valid_nxt  = 1'b1;
          vend_idx_nxt    = sel_idx;
          coin_reject_nxt = |coin_in;
        end else begin
          if (coin_in != '0) begin
            if (coin_ok) begin
              credit_nxt        = coin_sum;
              disp_value_nxt    = coin_sum;
              disp_is_price_nxt = 1'b0;
              state_nxt         = S_CREDIT;
            end else begin
              coin_reject_nxt = 1'b1;
            end
          end
          if (sel_valid && sel_ok) begin
            disp_value_nxt    = sel_price;
            disp_is_price_nxt = 1'b1;
          end
        end
      end
      S_VEND: begin
        stock_dec       = 1'b1;
        coin_reject_nxt = |coin_in;
        if (change != '0) begin
          state_nxt         = S_CHANGE;
          chg_valid_nxt     = 1'b1;
          chg_coin_nxt      = pick_coin(change);
          disp_value_nxt    = change;
          disp_is_price_nxt = 1'b0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        coin_reject_nxt = |coin_in;
        if (chg_valid && chg_ready) begin
          change_nxt     = remain;
          disp_value_nxt = remain;
          if (remain == '0) begin
            chg_valid_nxt = 1'b0;
            chg_coin_nxt  = '0;
            state_nxt     = S_IDLE;
          end else begin
            chg_coin_nxt = pick_coin(remain);
          end
        end
      end
    endcase
    busy_nxt = (state_nxt == S_VEND) || (state_nxt == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      credit        <= '0;
      change        <= '0;
      disp_value    <= '0;
      disp_is_price <= 1'b0;
      coin_reject   <= 1'b0;
      vend_valid    <= 1'b0;
      vend_idx      <= '0;
      chg_valid     <= 1'b0;
      chg_coin      <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit        <= credit_nxt;
      change        <= change_nxt;
      disp_value    <= disp_value_nxt;
      disp_is_price <= disp_is_price_nxt;
      coin_reject   <= coin_reject_nxt;
      vend_valid    <= vend_valid_nxt;
      vend_idx      <= vend_idx_nxt;
      chg_valid     <= chg_valid_nxt;
      chg_coin      <= chg_coin_nxt;
      busy          <= busy_nxt;
    end
  end

  // Price and stock table; the vended slot is held in vend_idx during VEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        price[i] <= PRICE_W'(DEFAULT_PRICE);
        stock[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      if (price_wr)   price[price_idx] <= price_data;
      if (restock_wr) stock[price_idx] <= '1;
      if (stock_dec && stock[vend_idx] != '0) stock[vend_idx] <= stock[vend_idx] - STOCK_W'(1);
    end
  end

  always_comb begin
    green_led = '0;
    red_led   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      red_led[i]   = (stock[i] == '0);
      green_led[i] = (credit >= price[i]) && (stock[i] != '0);
    end
  end

endmodule
